// File: rtl/ysyx_24090003_ifu_prefetch.sv
// Instruction fetch unit: sequential fetch over an AR/R read channel into a FIFO_DEPTH-entry
// {pc,inst,fault} prefetch buffer feeding IDU. Optional IFU_FAULT_EN enables fault entries + halt.
module ysyx_24090003_ifu_prefetch #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h8000_0000,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_inst_valid,
  input  logic            i_inst_ready,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_pc,
  output logic            o_inst_fault,
  output logic            o_mem_arvalid,
  input  logic            i_mem_arready,
  output logic [XLEN-1:0] o_mem_araddr,
  input  logic            i_mem_rvalid,
  output logic            o_mem_rready,
  input  logic [XLEN-1:0] i_mem_rdata,
  input  logic [1:0]      i_mem_rresp
);

`ifdef IFU_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_RESP  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] araddr_q, araddr_d;
  // The request on the bus belongs to a flushed stream; its response must be drained.
  logic            stale_q, stale_d;
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [XLEN-1:0]       pc_mem_q   [FIFO_DEPTH];
  logic [XLEN-1:0]       pc_mem_d   [FIFO_DEPTH];
  logic [XLEN-1:0]       inst_mem_q [FIFO_DEPTH];
  logic [XLEN-1:0]       inst_mem_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] flt_mem_q, flt_mem_d;

  logic            empty, pop, push, push_flt, misal, resp_err;
  logic [XLEN-1:0] push_inst;

  assign empty        = (cnt_q == '0);
  assign o_inst_valid = !empty && !i_redirect_valid;
  assign pop          = o_inst_valid && i_inst_ready;
  assign misal        = FAULT_EN && (fetch_pc_q[1:0] != 2'b00);
  assign resp_err     = FAULT_EN && (i_mem_rresp != 2'b00);

  assign o_inst        = empty ? '0 : inst_mem_q[rptr_q];
  assign o_pc          = empty ? '0 : pc_mem_q[rptr_q];
  assign o_inst_fault  = FAULT_EN && !empty && flt_mem_q[rptr_q];
  assign o_mem_arvalid = (state_q == S_REQ);
  assign o_mem_rready  = (state_q == S_RESP) || (state_q == S_DRAIN);
  assign o_mem_araddr  = araddr_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    araddr_d   = araddr_q;
    stale_d    = stale_q;
    push       = 1'b0;
    push_inst  = '0;
    push_flt   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cnt_q < DEPTH_C) begin
          if (misal) begin
            push     = 1'b1;
            push_flt = 1'b1;
            state_d  = S_HALT;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (i_mem_arready) begin
          state_d = stale_q ? S_DRAIN : S_RESP;
          stale_d = 1'b0;
        end
      end
      S_RESP: begin
        if (i_mem_rvalid) begin
          push       = 1'b1;
          push_inst  = i_mem_rdata;
          push_flt   = resp_err;
          fetch_pc_d = fetch_pc_q + XLEN'(4);
          // Chain the next request only if a slot remains after this push and any same-cycle pop.
          if (resp_err)                                   state_d = S_HALT;
          else if ((cnt_q + CW'(1) - CW'(pop)) < DEPTH_C) state_d = S_REQ;
          else                                            state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (i_mem_rvalid) state_d = S_IDLE;
      end
      S_HALT: ;
      default: state_d = S_IDLE;
    endcase

    if (i_redirect_valid) begin
      push       = 1'b0;
      fetch_pc_d = i_redirect_pc;
      case (state_q)
        S_REQ: begin
          if (i_mem_arready) begin
            state_d = S_DRAIN;
            stale_d = 1'b0;
          end else begin
            state_d = S_REQ;
            stale_d = 1'b1;
          end
        end
        S_RESP, S_DRAIN: state_d = i_mem_rvalid ? S_IDLE : S_DRAIN;
        default:         state_d = S_IDLE;
      endcase
    end

    // Address is captured on entry to REQ so it stays put across a redirect while stalled.
    if (state_d == S_REQ && state_q != S_REQ) araddr_d = fetch_pc_d;
  end

  always_comb begin
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    flt_mem_d  = flt_mem_q;
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    wptr_d     = wptr_q + AW'(push);
    rptr_d     = rptr_q + AW'(pop);
    if (push) begin
      pc_mem_d[wptr_q]   = fetch_pc_q;
      inst_mem_d[wptr_q] = push_inst;
      flt_mem_d[wptr_q]  = push_flt;
    end
    if (i_redirect_valid) begin
      cnt_d  = '0;
      wptr_d = '0;
      rptr_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      araddr_q   <= '0;
      stale_q    <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      araddr_q   <= araddr_d;
      stale_q    <= stale_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Entry storage is qualified by cnt_q, so it needs no reset.
  always_ff @(posedge i_clk) begin
    pc_mem_q   <= pc_mem_d;
    inst_mem_q <= inst_mem_d;
    flt_mem_q  <= flt_mem_d;
  end

endmodule

// File: tb/tb_ysyx_24090003_ifu_prefetch.sv
// Bench for ysyx_24090003_ifu_prefetch: directed scenarios plus randomized traffic, with an
// in-order scoreboard of expected {pc,inst,fault} rebuilt on every reset/redirect.
module tb_ysyx_24090003_ifu_prefetch;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_A5A5;

  logic        clk = 1'b0, rst = 1'b1;
  logic        redir_v = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        inst_valid, inst_ready = 1'b0, fault;
  logic [31:0] inst, pc;
  logic        arvalid, arready = 1'b0, rvalid = 1'b0, rready;
  logic [31:0] araddr, rdata = '0;
  logic [1:0]  rresp = '0;

  always #5 clk = ~clk;

  ysyx_24090003_ifu_prefetch dut (
    .i_clk(clk), .i_rst(rst),
    .i_redirect_valid(redir_v), .i_redirect_pc(redir_pc),
    .o_inst_valid(inst_valid), .i_inst_ready(inst_ready),
    .o_inst(inst), .o_pc(pc), .o_inst_fault(fault),
    .o_mem_arvalid(arvalid), .i_mem_arready(arready), .o_mem_araddr(araddr),
    .i_mem_rvalid(rvalid), .o_mem_rready(rready),
    .i_mem_rdata(rdata), .i_mem_rresp(rresp)
  );

  typedef struct packed { logic [31:0] pc; logic [31:0] inst; logic flt; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] exp_tail = RESET_PC;
  bit          exp_open = 1'b1;
  int          checks = 0, failures = 0;

  // stimulus knobs
  bit          rst_nxt = 1'b1, redir_nxt = 1'b0, inject_err = 1'b0;
  logic [31:0] redir_tgt = '0;
  int          rdy_pct = 100, ar_pct = 100, dly_min = 0, dly_max = 0;
  // memory model state
  bit          pend = 1'b0, done_ar = 1'b0, done_r = 1'b0;
  logic [31:0] paddr = '0, ar_lat = '0;
  int          pcnt = 0, ar_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One cycle: drive inputs at negedge, update memory model, leave caller at negedge+1.
  task automatic step();
    @(negedge clk);
    rst        = rst_nxt;
    redir_v    = redir_nxt;
    redir_pc   = redir_tgt;
    redir_nxt  = 1'b0;
    inst_ready = ($urandom_range(99) < rdy_pct);
    if (rst) begin
      exp_q.delete(); exp_tail = RESET_PC; exp_open = 1'b1;
    end else if (redir_v) begin
      exp_q.delete(); exp_tail = redir_pc; exp_open = 1'b1;
`ifdef IFU_FAULT_EN
      if (redir_pc[1:0] != 2'b00) begin
        exp_q.push_back('{redir_pc, 32'h0, 1'b1}); exp_open = 1'b0;
      end else if (inject_err) begin
        exp_q.push_back('{redir_pc, redir_pc ^ KEY, 1'b1}); exp_open = 1'b0;
      end
`endif
    end
    while (exp_open && exp_q.size() < 16) begin
      exp_q.push_back('{exp_tail, exp_tail ^ KEY, 1'b0});
      exp_tail += 32'd4;
    end
    if (rst) begin
      pend = 1'b0; rvalid = 1'b0; arready = 1'b0; done_ar = 1'b0; done_r = 1'b0;
    end else begin
      if (done_r) begin pend = 1'b0; rvalid = 1'b0; end
      if (done_ar) begin pend = 1'b1; paddr = ar_lat; pcnt = int'($urandom_range(dly_max, dly_min)); end
      if (pend && !rvalid) begin
        if (pcnt == 0) begin
          rvalid = 1'b1; rdata = paddr ^ KEY; rresp = inject_err ? 2'b10 : 2'b00;
        end else pcnt--;
      end
      arready = !pend && ($urandom_range(99) < ar_pct);
      done_ar = arvalid && arready;
      if (done_ar) begin ar_lat = araddr; ar_cnt++; end
      done_r = rvalid && rready;
    end
    #1;
  endtask

  function automatic bit sig(input int sel);
    case (sel)
      0:       return inst_valid;
      1:       return rready;
      default: return arvalid;
    endcase
  endfunction

  task automatic wait_sig(input string name, input int sel, input int budget);
    int n = 0;
    while (!sig(sel) && n < budget) begin step(); n++; end
    if (!sig(sel)) begin
      checks++; failures++;
      $display("FAIL %s timeout after %0d cycles", name, budget);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_valid"},   inst_valid, 0);
    chk({tag, "_arvalid"}, arvalid, 0);
    chk({tag, "_rready"},  rready, 0);
    chk({tag, "_inst"},    inst, 0);
    chk({tag, "_pc"},      pc, 0);
    chk({tag, "_fault"},   fault, 0);
  endtask

  // Monitor: pops the scoreboard on every accepted head and checks AR stability.
  bit          p_arv = 1'b0, p_ardy = 1'b0, p_rst = 1'b1;
  logic [31:0] p_addr = '0;
  exp_t        e;
  initial begin
    forever begin
      @(negedge clk); #2;
      if (!rst) begin
        if (p_arv && !p_ardy && !p_rst) begin
          chk("ar_hold_valid", arvalid, 1);
          chk("ar_hold_addr", araddr, p_addr);
        end
        if (inst_valid && inst_ready) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_underflow actual_pc=%h required=no_entry", pc);
          end else begin
            e = exp_q.pop_front();
            chk("sb_pc", pc, e.pc);
            chk("sb_inst", inst, e.inst);
            chk("sb_fault", fault, e.flt);
          end
        end
      end
      p_arv = arvalid; p_ardy = arready; p_rst = rst; p_addr = araddr;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] a0;
  bit          last_redir;
  initial begin
    repeat (3) step();
    chk_reset_outs("reset");

    // basic latency and throughput
    rst_nxt = 1'b0; step();
    chk("c0_valid", inst_valid, 0); chk("c0_arvalid", arvalid, 0);
    step();
    chk("c1_arvalid", arvalid, 1); chk("c1_araddr", araddr, RESET_PC); chk("c1_valid", inst_valid, 0);
    step();
    chk("c2_rvalid", rvalid, 1); chk("c2_valid", inst_valid, 0);
    step(); chk("c3_valid", inst_valid, 1); chk("c3_pc", pc, RESET_PC);
    step(); chk("c4_valid", inst_valid, 0);
    step(); chk("c5_valid", inst_valid, 1); chk("c5_pc", pc, RESET_PC + 4);
    step(); step(); chk("c7_valid", inst_valid, 1); chk("c7_pc", pc, RESET_PC + 8);

    // IDU stall fills exactly FIFO_DEPTH entries
    rdy_pct = 0; repeat (10) step();
    chk("stall_valid", inst_valid, 1); chk("stall_arvalid", arvalid, 0); chk("stall_rready", rready, 0);
    rdy_pct = 100;
    step(); chk("drain0_valid", inst_valid, 1);
    step(); chk("drain1_valid", inst_valid, 1);
    step(); chk("drain2_valid", inst_valid, 0);

    // redirect during RESP, stale beat arrives later
    dly_min = 2; dly_max = 2;
    wait_sig("t3_arvalid", 2, 20);
    redir_nxt = 1'b1; redir_tgt = 32'h8000_1000; step();
    chk("t3_in_resp", rready, 1); chk("t3_no_rvalid", rvalid, 0);
    wait_sig("t3_valid", 0, 40);
    chk("t3_pc", pc, 32'h8000_1000); chk("t3_inst", inst, 32'h8000_1000 ^ KEY);

    // redirect while request stalled
    dly_min = 0; dly_max = 0; ar_pct = 0; step();
    wait_sig("t4_arvalid", 2, 20);
    a0 = araddr;
    redir_nxt = 1'b1; redir_tgt = 32'h8000_1000; step();
    chk("t4_hold0", araddr, a0);
    step(); chk("t4_hold1", araddr, a0); chk("t4_hold1_v", arvalid, 1);
    step(); chk("t4_hold2", araddr, a0);
    ar_pct = 100; step(); chk("t4_accept_v", arvalid, 1); chk("t4_accept_a", araddr, a0);
    step(); chk("t4_drain_arvalid", arvalid, 0);
    wait_sig("t4_next_ar", 2, 20); chk("t4_next_addr", araddr, 32'h8000_1000);
    wait_sig("t4_valid", 0, 20); chk("t4_pc", pc, 32'h8000_1000);

`ifdef IFU_FAULT_EN
    rdy_pct = 0; repeat (10) step();
    redir_nxt = 1'b1; redir_tgt = 32'h8000_0002; ar_cnt = 0; step();
    rdy_pct = 100;
    wait_sig("t5_valid", 0, 10);
    chk("t5_fault", fault, 1); chk("t5_pc", pc, 32'h8000_0002); chk("t5_inst", inst, 0);
    repeat (20) step();
    chk("t5_no_ar", ar_cnt, 0);
    inject_err = 1'b1;
    redir_nxt = 1'b1; redir_tgt = 32'h8000_2000; step();
    ar_cnt = 0; repeat (25) step();
    chk("t5_one_ar", ar_cnt, 1); chk("t5_halt_arvalid", arvalid, 0);
    inject_err = 1'b0;
    redir_nxt = 1'b1; redir_tgt = RESET_PC; step();
`else
    // error responses are ignored in this build
    inject_err = 1'b1;
    redir_nxt = 1'b1; redir_tgt = 32'h8000_3000; step();
    wait_sig("rresp_valid", 0, 20);
    chk("rresp_pc", pc, 32'h8000_3000); chk("rresp_fault", fault, 0);
    repeat (20) step();
    inject_err = 1'b0;
    // misaligned addresses are issued as-is
    rdy_pct = 0; repeat (10) step();
    redir_nxt = 1'b1; redir_tgt = 32'h8000_0002; step();
    step();
    wait_sig("mis_ar", 2, 10); chk("mis_araddr", araddr, 32'h8000_0002);
    rdy_pct = 100;
    wait_sig("mis_valid", 0, 20); chk("mis_pc", pc, 32'h8000_0002);
`endif

    // address wrap, then reset mid-RESP
    redir_nxt = 1'b1; redir_tgt = 32'hFFFF_FFFC; step();
    wait_sig("wrap_valid0", 0, 30); chk("wrap_pc0", pc, 32'hFFFF_FFFC);
    step();
    wait_sig("wrap_valid1", 0, 30); chk("wrap_pc1", pc, 32'h0000_0000);
    dly_min = 3; dly_max = 3;
    wait_sig("rst_arvalid", 2, 20);
    rst_nxt = 1'b1; step();
    rst_nxt = 1'b0; step();
    chk_reset_outs("midrst");
    dly_min = 0; dly_max = 0;
    wait_sig("post_rst_valid", 0, 20); chk("post_rst_pc", pc, RESET_PC);

    // randomized traffic
    rdy_pct = 70; ar_pct = 60; dly_min = 0; dly_max = 3; last_redir = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(49) == 0 || (last_redir && $urandom_range(3) == 0)) begin
        redir_nxt = 1'b1;
        redir_tgt = {16'h8000, 16'($urandom)} & 32'hFFFF_FFFC;
`ifndef IFU_FAULT_EN
        if ($urandom_range(7) == 0) redir_tgt[1:0] = 2'($urandom_range(3));
        inject_err = ($urandom_range(3) == 0);
`endif
      end
      last_redir = redir_nxt;
      step();
    end
    inject_err = 1'b0; rdy_pct = 100; ar_pct = 100;
    repeat (30) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
